// File: rtl/seg_pkg.sv
// Shared seven-segment constants and helpers for the multi-digit display counter.
package seg_pkg;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] HEX_MAX   = 4'hF;

  // Active-high g..a pattern for one hex digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] p;
    case (digit)
      4'h0:    p = SEG_0;
      4'h1:    p = SEG_1;
      4'h2:    p = SEG_2;
      4'h3:    p = SEG_3;
      4'h4:    p = SEG_4;
      4'h5:    p = SEG_5;
      4'h6:    p = SEG_6;
      4'h7:    p = SEG_7;
      4'h8:    p = SEG_8;
      4'h9:    p = SEG_9;
      4'hA:    p = SEG_A;
      4'hB:    p = SEG_B;
      4'hC:    p = SEG_C;
      4'hD:    p = SEG_D;
      4'hE:    p = SEG_E;
      default: p = SEG_F;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] digit_max(input logic hex_mode);
    return hex_mode ? HEX_MAX : BCD_MAX;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational digit-to-segment decoder, active-low with DP forced off.
module seven_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      seg_c = {1'b1, ~seg_pattern(digit)};
    end
  end

endmodule

// File: rtl/multi_digit_segment_counter.sv
// Prescaled multi-digit hex/BCD up/down counter driving active-low seven-segment displays.
module multi_digit_segment_counter
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [8*NUM_DIGITS-1:0] hex,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    wrap
);

  localparam int unsigned VW = 4 * NUM_DIGITS;
  localparam int unsigned HW = 8 * NUM_DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]         presc;
  logic [PW-1:0]         presc_n;
  logic [VW-1:0]         value_n;
  logic                  wrap_pend;
  logic                  wrap_pend_n;
  logic                  tick;
  logic                  carry;
  logic [3:0]            d;
  logic [3:0]            dmax;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] blank;
  logic [HW-1:0]         hex_n;
  logic [HW-1:0]         rst_hex;

  assign tick = (presc == PRESC_LAST);

  // Load / step / hold selection with the digit ripple; carry doubles as borrow.
  always_comb begin
    value_n     = value;
    presc_n     = presc;
    wrap_pend_n = 1'b0;
    carry       = 1'b1;
    d           = 4'd0;
    dmax        = digit_max(hex_mode);
    if (load) begin
      presc_n = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        d = load_value[4*i +: 4];
        value_n[4*i +: 4] = (!hex_mode && (d > BCD_MAX)) ? BCD_MAX : d;
      end
    end else if (enable) begin
      presc_n = tick ? '0 : PW'(presc + 1'b1);
      if (tick) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          d = value[4*i +: 4];
          if (carry) begin
            if (up) begin
              if (d >= dmax) begin
                value_n[4*i +: 4] = 4'd0;
              end else begin
                value_n[4*i +: 4] = 4'(d + 4'd1);
                carry = 1'b0;
              end
            end else if (!hex_mode && (d > BCD_MAX)) begin
              value_n[4*i +: 4] = BCD_MAX;
              carry = 1'b0;
            end else if (d == 4'd0) begin
              value_n[4*i +: 4] = dmax;
            end else begin
              value_n[4*i +: 4] = 4'(d - 4'd1);
              carry = 1'b0;
            end
          end
        end
        wrap_pend_n = carry;
      end
    end
  end

  // Leading-zero blanking: a digit blanks only if it and all digits above are zero.
  always_comb begin
    blank    = '0;
    all_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero && (value[4*i +: 4] == 4'd0);
      blank[i] = blank_lz && all_zero;
    end
  end

  always_comb begin
    rst_hex = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      rst_hex[8*i +: 8] = ((i != 0) && blank_lz) ? SEG_BLANK : {1'b1, ~SEG_0};
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_dig
    seven_seg_decoder u_dec (
      .digit (value[4*g +: 4]),
      .blank (blank[g]),
      .seg_c (hex_n[8*g +: 8])
    );
  end

  // wrap is delayed one extra stage so it lines up with the display update.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      value     <= '0;
      wrap_pend <= 1'b0;
      wrap      <= 1'b0;
      hex       <= rst_hex;
    end else begin
      presc     <= presc_n;
      value     <= value_n;
      wrap_pend <= wrap_pend_n;
      wrap      <= wrap_pend;
      hex       <= hex_n;
    end
  end

endmodule

// File: tb/tb_multi_digit_segment_counter.sv
// Randomized self-checking bench for multi_digit_segment_counter with a digit-level reference model.
module tb_multi_digit_segment_counter;

  localparam int unsigned ND = 2;
  localparam int unsigned TD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          up;
  logic          hex_mode;
  logic          blank_lz;
  logic          load;
  logic [4*ND-1:0] load_value;
  logic [8*ND-1:0] hex;
  logic [4*ND-1:0] value;
  logic          wrap;

  int n_checks = 0;
  int n_errors = 0;

  int              m_presc;
  logic [4*ND-1:0] m_val;
  logic            m_wrap_pend;
  logic            m_wrap;
  logic [8*ND-1:0] m_hex;

  always #5 clk = ~clk;

  multi_digit_segment_counter #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .up         (up),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .load       (load),
    .load_value (load_value),
    .hex        (hex),
    .value      (value),
    .wrap       (wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_ref(input int dg);
    logic [6:0] p;
    case (dg)
      0:  p = 7'b0111111;  1:  p = 7'b0000110;  2:  p = 7'b1011011;  3:  p = 7'b1001111;
      4:  p = 7'b1100110;  5:  p = 7'b1101101;  6:  p = 7'b1111101;  7:  p = 7'b0000111;
      8:  p = 7'b1111111;  9:  p = 7'b1101111;  10: p = 7'b1110111;  11: p = 7'b1111100;
      12: p = 7'b0111001;  13: p = 7'b1011110;  14: p = 7'b1111001;  default: p = 7'b1110001;
    endcase
    return {1'b1, ~p};
  endfunction

  function automatic logic [8*ND-1:0] hex_ref(input logic [4*ND-1:0] v, input logic blk);
    logic [8*ND-1:0] h;
    bit zero_above;
    h = '0;
    zero_above = 1'b1;
    for (int i = int'(ND) - 1; i >= 0; i--) begin
      zero_above = zero_above && (v[4*i +: 4] == 4'd0);
      h[8*i +: 8] = (i >= 1 && blk && zero_above) ? 8'hFF : seg_ref(int'(v[4*i +: 4]));
    end
    return h;
  endfunction

  function automatic logic [4*ND-1:0] sat_ref(input logic [4*ND-1:0] v, input logic hexm);
    logic [4*ND-1:0] r;
    r = v;
    for (int i = 0; i < int'(ND); i++) begin
      if (!hexm && v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Hex mode is plain modular arithmetic; BCD mode locates the first digit that absorbs the carry/borrow.
  task automatic step_ref(input logic [4*ND-1:0] v, input logic upd, input logic hexm,
                          output logic [4*ND-1:0] nv, output logic w);
    int n, full, k;
    int dg[ND];
    w  = 1'b0;
    nv = v;
    full = 1 << (4 * ND);
    if (hexm) begin
      n = int'(v);
      if (upd) begin
        w = (n == full - 1);
        n = (n + 1) % full;
      end else begin
        w = (n == 0);
        n = (n + full - 1) % full;
      end
      nv = (4*ND)'(n);
    end else begin
      for (int i = 0; i < int'(ND); i++) dg[i] = int'(v[4*i +: 4]);
      k = -1;
      if (upd) begin
        for (int i = 0; i < int'(ND); i++) if (k < 0 && dg[i] < 9) k = i;
        if (k < 0) begin
          for (int i = 0; i < int'(ND); i++) dg[i] = 0;
          w = 1'b1;
        end else begin
          for (int i = 0; i < k; i++) dg[i] = 0;
          dg[k] = dg[k] + 1;
        end
      end else begin
        for (int i = 0; i < int'(ND); i++) if (k < 0 && dg[i] != 0) k = i;
        if (k < 0) begin
          for (int i = 0; i < int'(ND); i++) dg[i] = 9;
          w = 1'b1;
        end else begin
          for (int i = 0; i < k; i++) dg[i] = 9;
          dg[k] = (dg[k] > 9) ? 9 : dg[k] - 1;
        end
      end
      for (int i = 0; i < int'(ND); i++) nv[4*i +: 4] = 4'(dg[i]);
    end
  endtask

  // Advance model and DUT one clock with the current inputs, then compare.
  task automatic do_cycle();
    logic [4*ND-1:0] nv;
    logic            nw;
    nv = m_val;
    nw = 1'b0;
    m_hex = hex_ref(reset ? '0 : m_val, blank_lz);
    if (reset) begin
      m_presc = 0;
      nv = '0;
    end else if (load) begin
      nv = sat_ref(load_value, hex_mode);
      m_presc = 0;
    end else if (enable) begin
      if (m_presc == int'(TD) - 1) begin
        step_ref(m_val, up, hex_mode, nv, nw);
        m_presc = 0;
      end else begin
        m_presc++;
      end
    end
    m_wrap      = reset ? 1'b0 : m_wrap_pend;
    m_wrap_pend = reset ? 1'b0 : nw;
    m_val       = nv;
    @(posedge clk);
    #1;
    check("value", 32'(value), 32'(m_val));
    check("hex",   32'(hex),   32'(m_hex));
    check("wrap",  32'(wrap),  32'(m_wrap));
  endtask

  task automatic load_cycle(input logic [4*ND-1:0] lv);
    load = 1'b1;
    load_value = lv;
    do_cycle();
    load = 1'b0;
  endtask

  initial begin
    m_presc = 0; m_val = '0; m_wrap_pend = 1'b0; m_wrap = 1'b0; m_hex = '0;
    reset = 1'b1; enable = 1'b0; up = 1'b1; hex_mode = 1'b1; blank_lz = 1'b0;
    load = 1'b0; load_value = '0;
    do_cycle();
    check("rst_value", 32'(value), 32'h0);
    check("rst_hex",   32'(hex),   32'hC0C0);

    // Hex up, three ticks.
    reset = 1'b0; enable = 1'b1;
    repeat (12) do_cycle();
    check("plan_cnt3", 32'(value), 32'h03);
    do_cycle();
    check("plan_hex3", 32'(hex), 32'hC0B0);

    // BCD wrap 99 -> 00.
    hex_mode = 1'b0;
    load_cycle(8'h99);
    repeat (4) do_cycle();
    check("bcd_wrap_val", 32'(value), 32'h00);
    do_cycle();
    check("bcd_wrap_pulse", 32'(wrap), 32'h1);
    check("bcd_wrap_hex", 32'(hex), 32'hC0C0);
    do_cycle();
    check("bcd_wrap_end", 32'(wrap), 32'h0);

    // Hex down across a borrow and through zero.
    hex_mode = 1'b1; up = 1'b0;
    load_cycle(8'h10);
    repeat (4) do_cycle();
    check("hdown_0f", 32'(value), 32'h0F);
    repeat (4) do_cycle();
    check("hdown_0e", 32'(value), 32'h0E);
    load_cycle(8'h00);
    repeat (4) do_cycle();
    check("hdown_ff", 32'(value), 32'hFF);
    do_cycle();
    check("hdown_wrap", 32'(wrap), 32'h1);

    // BCD load saturation and invalid digit on a down step.
    hex_mode = 1'b0;
    load_cycle(8'hAB);
    check("bcd_sat", 32'(value), 32'h99);
    hex_mode = 1'b1;
    load_cycle(8'h0C);
    hex_mode = 1'b0;
    repeat (4) do_cycle();
    check("bcd_inv_down", 32'(value), 32'h09);

    // Leading-zero blanking.
    blank_lz = 1'b1; hex_mode = 1'b1; up = 1'b1;
    load_cycle(8'h05);
    do_cycle();
    check("blank_05", 32'(hex), 32'hFF92);
    load_cycle(8'h00);
    do_cycle();
    check("blank_00", 32'(hex), 32'hFFC0);

    // Freeze mid-prescale, then resume.
    blank_lz = 1'b0;
    load_cycle(8'h20);
    repeat (2) do_cycle();
    enable = 1'b0;
    repeat (10) do_cycle();
    check("freeze_hold", 32'(value), 32'h20);
    enable = 1'b1;
    repeat (2) do_cycle();
    check("resume_step", 32'(value), 32'h21);

    // Load coincident with tick, then reset coincident with tick.
    repeat (3) do_cycle();
    load_cycle(8'h44);
    check("load_tick", 32'(value), 32'h44);
    repeat (3) do_cycle();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    check("reset_tick", 32'(value), 32'h00);
    repeat (4) do_cycle();
    check("first_tick", 32'(value), 32'h01);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load       = ($urandom_range(0, 15) == 0);
      load_value = (4*ND)'($urandom);
      enable     = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) up = ~up;
      if ($urandom_range(0, 31) == 0) hex_mode = ~hex_mode;
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
